// File: rtl/bmp_loader.sv
`default_nettype none
// ============================================================================
// Module      : bmp_loader
// Description : Streams a 24x64 bitmap from word memory into a packed register
//               and hands it to the downstream bitmap ALU with a write pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_loader (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   baseaddr,
    input  logic          alubusy,
    output logic          rd_en,
    output logic [15:0]   rd_addr,
    input  logic [23:0]   rd_data,
    output logic [1535:0] bmpout,
    output logic          wren,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0]  c_ST_IDLE  = 3'd0;
    localparam logic [2:0]  c_ST_FETCH = 3'd1;
    localparam logic [2:0]  c_ST_LAST  = 3'd2;
    localparam logic [2:0]  c_ST_WAIT  = 3'd3;
    localparam logic [2:0]  c_ST_WRITE = 3'd4;
    localparam logic [5:0]  c_LAST_ROW = 6'd63;
    localparam logic [10:0] c_ROW_W    = 11'd24;

    logic [2:0]    r_state;
    logic [5:0]    r_row;
    logic [15:0]   r_base;
    logic          r_rd_en;
    logic [15:0]   r_rd_addr;
    logic          r_cap_vld;
    logic [5:0]    r_cap_row;
    logic [1535:0] r_bmp;
    logic          r_wren;
    logic          r_done;

    logic [5:0]    w_row_inc;
    logic [15:0]   w_next_addr;
    logic [10:0]   w_cap_lsb;

    assign w_row_inc   = r_row + 6'd1;
    assign w_next_addr = r_base + {10'd0, w_row_inc};
    assign w_cap_lsb   = {5'd0, r_cap_row} * c_ROW_W;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_row     <= 6'd0;
            r_base    <= 16'd0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 16'd0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wren <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_base    <= baseaddr;
                        r_row     <= 6'd0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= baseaddr;
                        r_state   <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    // r_row is the row whose address is on rd_addr this cycle
                    if (r_row == c_LAST_ROW) begin
                        r_rd_en <= 1'b0;
                        r_state <= c_ST_LAST;
                    end else begin
                        r_row     <= w_row_inc;
                        r_rd_addr <= w_next_addr;
                    end
                end
                c_ST_LAST: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (!alubusy) begin
                        r_wren  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    r_wren  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_wren  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Read data lags its strobe by one cycle; the row tag travels alongside it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_vld <= 1'b0;
            r_cap_row <= 6'd0;
            r_bmp     <= '0;
        end else begin
            r_cap_vld <= r_rd_en;
            r_cap_row <= r_row;
            if (r_cap_vld) begin
                r_bmp[w_cap_lsb +: 24] <= rd_data;
            end
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign bmpout  = r_bmp;
    assign wren    = r_wren;
    assign done    = r_done;
    assign busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bmp_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_loader
// Description : Directed self-checking bench for bmp_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_loader;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   baseaddr;
    logic          alubusy;
    logic          rd_en;
    logic [15:0]   rd_addr;
    logic [23:0]   rd_data;
    logic [1535:0] bmpout;
    logic          wren;
    logic          busy;
    logic          done;

    int            n_tests;
    int            n_fail;
    logic [15:0]   mem_ofs;
    logic [23:0]   mem_seed;

    bmp_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .baseaddr (baseaddr),
        .alubusy  (alubusy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .bmpout   (bmpout),
        .wren     (wren),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory: byte (addr - mem_ofs) replicated, xored with a seed
    function automatic logic [23:0] memf(input logic [15:0] a);
        logic [15:0] d;
        d = a - mem_ofs;
        return {d[7:0], d[7:0], d[7:0]} ^ mem_seed;
    endfunction

    always @(posedge clk) begin
        rd_data <= rd_en ? memf(rd_addr) : 24'hDEAD5A;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; baseaddr = 16'h1234; alubusy = 1'b1;
        tick; tick; tick;
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
        n_tests++; if (rd_addr !== 16'h0) begin n_fail++; $display("FAIL reset_rd_addr got %h exp 0000", rd_addr); end
        n_tests++; if (wren !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_wren_done got %b%b exp 00", wren, done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (bmpout !== '0) begin n_fail++; $display("FAIL reset_bmpout got nonzero exp zero"); end
        rst_n = 1'b1; start = 1'b0; alubusy = 1'b0;
        tick;
        n_tests++; if (busy !== 1'b0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_no_queue busy=%b rd_en=%b exp 0 0", busy, rd_en); end
        tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_basic;
        logic [15:0] base;
        logic [23:0] exp_row;
        base = 16'h0100; mem_ofs = base; mem_seed = 24'h0;
        baseaddr = base; alubusy = 1'b0; start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick;
            start = 1'b0;
            n_tests++; if (rd_en !== (c <= 64)) begin n_fail++; $display("FAIL basic_rd_en c=%0d got %b exp %b", c, rd_en, (c <= 64)); end
            if (c <= 64) begin
                n_tests++; if (rd_addr !== base + 16'(c - 1)) begin n_fail++; $display("FAIL basic_rd_addr c=%0d got %h exp %h", c, rd_addr, base + 16'(c - 1)); end
            end
            n_tests++; if (wren !== (c == 67) || done !== (c == 67)) begin n_fail++; $display("FAIL basic_wren_done c=%0d got %b%b exp %b", c, wren, done, (c == 67)); end
            n_tests++; if (busy !== (c <= 67)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, (c <= 67)); end
        end
        for (int k = 0; k < 64; k++) begin
            exp_row = 24'(k) * 24'h010101;
            n_tests++; if (bmpout[24*k +: 24] !== exp_row) begin n_fail++; $display("FAIL basic_row%0d got %h exp %h", k, bmpout[24*k +: 24], exp_row); end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] base;
        logic [15:0] a;
        logic [23:0] exp_row;
        base = 16'hFFF0; mem_ofs = 16'h0; mem_seed = 24'h5A5A5A;
        baseaddr = base; start = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            tick;
            start = 1'b0;
            if (c <= 64) begin
                n_tests++; if (rd_en !== 1'b1 || rd_addr !== base + 16'(c - 1)) begin n_fail++; $display("FAIL wrap_rd_addr c=%0d got %b/%h exp 1/%h", c, rd_en, rd_addr, base + 16'(c - 1)); end
            end
            if (c == 17) begin
                n_tests++; if (rd_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", rd_addr); end
            end
            n_tests++; if (wren !== (c == 67)) begin n_fail++; $display("FAIL wrap_wren c=%0d got %b exp %b", c, wren, (c == 67)); end
        end
        n_tests++; if (bmpout[24*16 +: 24] !== 24'h5A5A5A) begin n_fail++; $display("FAIL wrap_row16 got %h exp 5a5a5a", bmpout[24*16 +: 24]); end
        for (int k = 0; k < 64; k++) begin
            a = base + 16'(k);
            exp_row = {a[7:0], a[7:0], a[7:0]} ^ 24'h5A5A5A;
            n_tests++; if (bmpout[24*k +: 24] !== exp_row) begin n_fail++; $display("FAIL wrap_row%0d got %h exp %h", k, bmpout[24*k +: 24], exp_row); end
        end
    endtask

    task automatic test_backpressure;
        logic [1535:0] img;
        logic [15:0]   base;
        base = 16'h0800; mem_ofs = base; mem_seed = 24'h0F0F0F;
        for (int k = 0; k < 64; k++) img[24*k +: 24] = {3{8'(k)}} ^ 24'h0F0F0F;
        baseaddr = base; alubusy = 1'b1; start = 1'b1;
        for (int c = 1; c <= 104; c++) begin
            tick;
            start = 1'b0;
            if (c == 101) alubusy = 1'b0;
            n_tests++; if (wren !== (c == 102) || done !== (c == 102)) begin n_fail++; $display("FAIL bp_wren c=%0d got %b%b exp %b", c, wren, done, (c == 102)); end
            n_tests++; if (busy !== (c <= 102)) begin n_fail++; $display("FAIL bp_busy c=%0d got %b exp %b", c, busy, (c <= 102)); end
            if (c == 66 || c == 100 || c == 102) begin
                n_tests++; if (bmpout !== img) begin n_fail++; $display("FAIL bp_image c=%0d row0 got %h exp %h", c, bmpout[23:0], img[23:0]); end
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [1535:0] img;
        logic [15:0]   base;
        base = 16'h0200; mem_ofs = base; mem_seed = 24'h111111;
        for (int k = 0; k < 64; k++) img[24*k +: 24] = {3{8'(k)}} ^ 24'h111111;
        baseaddr = base; alubusy = 1'b0; start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick;
            start = (c == 10 || c == 40);
            if (c == 5) baseaddr = 16'h0300;
            n_tests++; if (rd_en !== (c <= 64)) begin n_fail++; $display("FAIL ign_rd_en c=%0d got %b exp %b", c, rd_en, (c <= 64)); end
            if (c <= 64) begin
                n_tests++; if (rd_addr !== base + 16'(c - 1)) begin n_fail++; $display("FAIL ign_rd_addr c=%0d got %h exp %h", c, rd_addr, base + 16'(c - 1)); end
            end
            n_tests++; if (wren !== (c == 67)) begin n_fail++; $display("FAIL ign_wren c=%0d got %b exp %b", c, wren, (c == 67)); end
            n_tests++; if (busy !== (c <= 67)) begin n_fail++; $display("FAIL ign_busy c=%0d got %b exp %b", c, busy, (c <= 67)); end
        end
        n_tests++; if (bmpout !== img) begin n_fail++; $display("FAIL ign_image row63 got %h exp %h", bmpout[1535:1512], img[1535:1512]); end
    endtask

    task automatic test_midload_reset;
        logic [1535:0] img;
        logic [15:0]   base;
        base = 16'h0400; mem_ofs = base; mem_seed = 24'h222222;
        baseaddr = base; alubusy = 1'b0; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick;
            start = 1'b0;
            rst_n = (c != 30);
            if (c < 30) begin
                n_tests++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_rd_en c=%0d got %b exp 1", c, rd_en); end
            end else if (c > 30) begin
                n_tests++; if (busy !== 1'b0 || rd_en !== 1'b0 || wren !== 1'b0) begin n_fail++; $display("FAIL mid_abort c=%0d busy/rd_en/wren got %b%b%b exp 000", c, busy, rd_en, wren); end
                n_tests++; if (bmpout !== '0) begin n_fail++; $display("FAIL mid_bmpout c=%0d row29 got %h exp 000000", c, bmpout[24*29 +: 24]); end
                n_tests++; if (rd_addr !== 16'h0) begin n_fail++; $display("FAIL mid_rd_addr c=%0d got %h exp 0000", c, rd_addr); end
            end
        end
        base = 16'h0500; mem_ofs = base; mem_seed = 24'h333333;
        for (int k = 0; k < 64; k++) img[24*k +: 24] = {3{8'(k)}} ^ 24'h333333;
        baseaddr = base; start = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            tick;
            start = 1'b0;
            n_tests++; if (wren !== (c == 67)) begin n_fail++; $display("FAIL mid_reload_wren c=%0d got %b exp %b", c, wren, (c == 67)); end
        end
        n_tests++; if (bmpout !== img) begin n_fail++; $display("FAIL mid_reload_image row0 got %h exp %h", bmpout[23:0], img[23:0]); end
    endtask

    task automatic test_back_to_back;
        logic [1535:0] img1;
        logic [1535:0] img2;
        logic          exp_en;
        for (int k = 0; k < 64; k++) begin
            img1[24*k +: 24] = {3{8'(k)}} ^ 24'h444444;
            img2[24*k +: 24] = {3{8'(k)}} ^ 24'h555555;
        end
        mem_ofs = 16'h0A00; mem_seed = 24'h444444;
        baseaddr = 16'h0A00; alubusy = 1'b0; start = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            tick;
            start = (c == 68);
            if (c == 68) begin
                baseaddr = 16'h0B00; mem_ofs = 16'h0B00; mem_seed = 24'h555555;
            end
            exp_en = (c <= 64) || (c >= 69 && c <= 132);
            n_tests++; if (rd_en !== exp_en) begin n_fail++; $display("FAIL b2b_rd_en c=%0d got %b exp %b", c, rd_en, exp_en); end
            n_tests++; if (wren !== (c == 67 || c == 135)) begin n_fail++; $display("FAIL b2b_wren c=%0d got %b exp %b", c, wren, (c == 67 || c == 135)); end
            if (c == 69) begin
                n_tests++; if (rd_addr !== 16'h0B00) begin n_fail++; $display("FAIL b2b_rd_addr got %h exp 0b00", rd_addr); end
            end
            if (c >= 67 && c <= 70) begin
                n_tests++; if (bmpout !== img1) begin n_fail++; $display("FAIL b2b_hold c=%0d row0 got %h exp %h", c, bmpout[23:0], img1[23:0]); end
            end
            if (c == 71) begin
                n_tests++; if (bmpout[23:0] !== img2[23:0] || bmpout[1535:24] !== img1[1535:24]) begin n_fail++; $display("FAIL b2b_first_row got %h exp %h", bmpout[23:0], img2[23:0]); end
            end
        end
        n_tests++; if (bmpout !== img2) begin n_fail++; $display("FAIL b2b_image row63 got %h exp %h", bmpout[1535:1512], img2[1535:1512]); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; baseaddr = 16'h0; alubusy = 1'b0;
        mem_ofs = 16'h0; mem_seed = 24'h0;
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_ignored_start;
        test_midload_reset;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmp_loader.md
BMP_LOADER -- requirements
Module: bmp_loader

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 start  input  1  request to load one 24x64 bitmap; sampled only in IDLE.
REQ-004 baseaddr  input  16  word address of bitmap row 0; latched when start is accepted.
REQ-005 alubusy  input  1  downstream bitmap register/ALU still processing; while high, the wren pulse is held off.
REQ-006 rd_en  output  1  memory read strobe, one word per cycle.
REQ-007 rd_addr  output  16  memory word address.
REQ-008 rd_data  input  24  memory read data; valid exactly one cycle after the matching rd_en.
REQ-009 bmpout  output  1536  packed bitmap; row k occupies bits [24k+23:24k].
REQ-010 wren  output  1  one-cycle write strobe to the bitmap register.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse, coincident with wren.

Function
REQ-013 States SHALL be IDLE, FETCH, LAST, WAIT and WRITE.
REQ-014 IDLE: start=1 SHALL latch baseaddr, clear the row counter to 0 and move to FETCH; start=0 SHALL keep the block in IDLE.
REQ-015 FETCH: each cycle SHALL assert rd_en=1 with rd_addr = latched base + k, where k is the row counter (0..63); k SHALL increment by 1 per cycle.
REQ-016 Address arithmetic SHALL be modulo 2^16; base 0xFFF0 wraps to 0x0000 after 0xFFFF.
REQ-017 After issuing k=63, the next state SHALL be LAST; rd_en SHALL be 0 in every state other than FETCH.
REQ-018 rd_data returned one cycle after the read for row k SHALL be written to bmpout[24k+23:24k]; all other bits SHALL be unchanged.
REQ-019 LAST: the block SHALL capture row 63, then move to WAIT.
REQ-020 WAIT: if alubusy=0, the block SHALL move to WRITE; otherwise it SHALL stay in WAIT indefinitely.
REQ-021 WRITE: wren=1 and done=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-022 wren and done SHALL be registered outputs, and SHALL be 0 in all states except WRITE.
REQ-023 bmpout SHALL remain stable from WRITE until the first rd_data capture of the next load.
REQ-024 Latency: start accepted at cycle T gives rd_en in cycles T+1..T+64, captures in T+2..T+65, and wren at T+67 when alubusy=0 throughout.
REQ-025 start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-026 start and alubusy asserted in the same IDLE cycle: start SHALL be accepted, and alubusy SHALL affect only the WAIT state.
REQ-027 Changes to baseaddr after acceptance SHALL NOT affect the rd_addr sequence in progress.

Reset
REQ-028 rst_n=0 SHALL force: state IDLE, row counter 0, latched base 0, rd_en 0, rd_addr 0, wren 0, done 0, busy 0, bmpout all zeros.
REQ-029 Reset asserted mid-load (any non-IDLE state) SHALL abort the load; no wren SHALL follow, and one-cycle-late rd_data SHALL be discarded.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 Basic load: base=0x0100, memory[0x0100+k]=k*0x010101, alubusy=0, start pulse at T -> 64 rd_en cycles with addresses 0x0100..0x013F, wren/done high only at T+67, bmpout[24k+23:24k]=k*0x010101 for all k.
REQ-032 Address wrap: base=0xFFF0 -> rd_addr sequence 0xFFF0..0xFFFF, then 0x0000..0x002F; row 16 taken from address 0x0000.
REQ-033 Backpressure: alubusy=1 from T until T+100 -> state stays WAIT, wren=0 through T+100, wren pulse at T+102, bmpout unchanged while waiting.
REQ-034 Ignored start: start re-pulsed at T+10 and T+40, baseaddr changed at T+5 -> single wren, rd_addr sequence unchanged, no second load.
REQ-035 Mid-load reset: rst_n=0 at T+30 for 1 cycle -> busy=0 and bmpout=0 from next cycle, no wren; a subsequent start completes a normal load.
REQ-036 Back-to-back: start at T+68 (first IDLE cycle after WRITE) -> second load accepted; bmpout holds first image until T+70.
